// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one picorv32-native slave bus between a CPU (m0) and a DMA (m1)
// Ports: clk, reset (synchronous, active-high)
//        m0_* / m1_*  : master request (valid, instr, addr, wdata, wstrb) and response (ready, rdata)
//        s_*          : shared slave request toward the address decoder and its response
//        grant        : one-hot owner, bit0 = m0, bit1 = m1, 00 = idle
//        timeout_err  : sticky flag, set when an access was completed by the timeout
// Optional: define MEM_ARBITER_TIMEOUT_EN to complete a stalled access with ERR_RDATA after
//           TIMEOUT_CYCLES owned cycles; without it the arbiter waits for s_ready indefinitely.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
    state_t state;
    logic last;
    logic own0, own1, own_valid, to;
    logic [31:0] rsp;
    // outputs are held at 0 throughout a reset cycle, even while an access is in flight
    assign own0      = state == OWN0 && !reset;
    assign own1      = state == OWN1 && !reset;
    assign own_valid = (own0 && m0_valid) || (own1 && m1_valid);
    assign grant     = {own1, own0};
    // the timeout completion cycle is answered locally, so the slave sees no request
    assign s_valid   = own_valid && !to;
    assign s_instr   = own0 ? m0_instr : own1 ? m1_instr : 1'b0;
    assign s_addr    = own0 ? m0_addr  : own1 ? m1_addr  : 32'd0;
    assign s_wdata   = own0 ? m0_wdata : own1 ? m1_wdata : 32'd0;
    assign s_wstrb   = own0 ? m0_wstrb : own1 ? m1_wstrb : 4'd0;
    assign m0_ready  = own0 && (s_ready || to);
    assign m1_ready  = own1 && (s_ready || to);
    assign rsp       = to ? ERR_RDATA : s_rdata;
    assign m0_rdata  = m0_ready ? rsp : 32'd0;
    assign m1_rdata  = m1_ready ? rsp : 32'd0;
    // last = master served by the most recent completed access; the other one wins a tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid && (!m1_valid || last))
                        state <= OWN0;
                    else if (m1_valid)
                        state <= OWN1;
                end
                default: begin
                    if (m0_ready || m1_ready) begin
                        state <= IDLE;
                        last  <= state == OWN1;
                    end else if (!own_valid) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
`ifdef MEM_ARBITER_TIMEOUT_EN
    logic [15:0] cnt;
    // s_ready in the expiry cycle wins, so expiry requires it to be low
    assign to = own_valid && !s_ready && cnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            cnt         <= (own0 || own1) && !s_ready ? cnt + 16'd1 : 16'd0;
            timeout_err <= timeout_err || to;
        end
    end
`else
    assign to          = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-programmable slave model
module tb_mem_arbiter;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 1'b0, m0_instr = 1'b0;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
    logic [3:0]  m0_wstrb = 4'd0;
    logic        m1_valid = 1'b0, m1_instr = 1'b0;
    logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
    logic [3:0]  m1_wstrb = 4'd0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = 32'd0;
    logic [1:0]  grant;
    logic        timeout_err;
    int          errors = 0, checks = 0;
    logic [31:0] q0[$], q1[$];
    logic [31:0] e0, e1;
    int          slv_lat = 1, slv_cnt = 0;
    bit          slv_mute = 1'b0;

    mem_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a * 32'd3 + 32'h1234_5648;
    endfunction

    // slave: raises s_ready (registered) after s_valid has been seen for slv_lat edges
    always @(posedge clk) begin
        if (reset || !s_valid || s_ready || slv_mute) begin
            s_ready <= 1'b0;
            slv_cnt <= 0;
        end else if (slv_cnt + 1 >= slv_lat) begin
            s_ready <= 1'b1;
            s_rdata <= rd_of(s_addr);
        end else begin
            slv_cnt <= slv_cnt + 1;
        end
    end

    // response scoreboard: every master ready must match the next expected rdata
    always @(negedge clk) begin
        if (m0_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL m0_resp: unexpected ready, rdata=%h", m0_rdata);
            end else begin
                e0 = q0.pop_front();
                if (m0_rdata !== e0) begin
                    errors++;
                    $display("FAIL m0_resp: rdata=%h expected %h", m0_rdata, e0);
                end
            end
        end
        if (m1_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL m1_resp: unexpected ready, rdata=%h", m1_rdata);
            end else begin
                e1 = q1.pop_front();
                if (m1_rdata !== e1) begin
                    errors++;
                    $display("FAIL m1_resp: rdata=%h expected %h", m1_rdata, e1);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        tick;
        tick;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b expected 0", s_valid); end
        checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", m1_ready, m0_ready); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        tick;
        reset = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
    endtask

    task automatic test_single;
        logic [1:0] eg [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        logic       es [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       er [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        slv_lat = 2;
        m0_valid = 1'b1;
        m0_instr = 1'b0;
        m0_addr = 32'h0000_0010;
        m0_wstrb = 4'd0;
        q0.push_back(32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (grant !== eg[i]) begin errors++; $display("FAIL single_grant[%0d]: got %b expected %b", i, grant, eg[i]); end
            checks++; if (s_valid !== es[i]) begin errors++; $display("FAIL single_s_valid[%0d]: got %b expected %b", i, s_valid, es[i]); end
            checks++; if (m0_ready !== er[i]) begin errors++; $display("FAIL single_m0_ready[%0d]: got %b expected %b", i, m0_ready, er[i]); end
            if (i == 1) begin
                checks++; if (s_addr !== 32'h10) begin errors++; $display("FAIL single_s_addr: got %h expected 00000010", s_addr); end
            end
            tick;
            if (i == 3) m0_valid = 1'b0;
        end
        checks++; if (q0.size() != 0) begin errors++; $display("FAIL single_pending: got %0d expected 0", q0.size()); end
    endtask

    task automatic test_contention;
        logic [1:0] eg [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                                2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        int code = 0, n0 = 0, n1 = 0;
        logic r0, r1;
        slv_lat = 1;
        reset = 1'b1;
        m0_valid = 1'b1;
        m0_addr = 32'h100;
        m1_valid = 1'b1;
        m1_instr = 1'b0;
        m1_addr = 32'h200;
        m1_wstrb = 4'd0;
        q0.push_back(rd_of(32'h100));
        q1.push_back(rd_of(32'h200));
        tick;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (grant !== eg[i]) begin errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, grant, eg[i]); end
            r0 = m0_ready;
            r1 = m1_ready;
            if (r0) code = code * 10 + 1;
            if (r1) code = code * 10 + 2;
            tick;
            if (r0) begin
                n0++;
                if (n0 < 2) begin m0_addr = 32'h104; q0.push_back(rd_of(32'h104)); end
                else m0_valid = 1'b0;
            end
            if (r1) begin
                n1++;
                if (n1 < 2) begin m1_addr = 32'h204; q1.push_back(rd_of(32'h204)); end
                else m1_valid = 1'b0;
            end
        end
        checks++; if (code != 1212) begin errors++; $display("FAIL contention_order: got %0d expected 1212 (1=m0,2=m1)", code); end
        checks++; if (q0.size() + q1.size() != 0) begin errors++; $display("FAIL contention_pending: got %0d expected 0", q0.size() + q1.size()); end
    endtask

    task automatic test_write;
        int seen = 0;
        logic r1;
        slv_lat = 2;
        m0_addr = 32'hFFFF_0000;
        m0_wdata = 32'h5555_AAAA;
        m0_wstrb = 4'b1100;
        m1_valid = 1'b1;
        m1_instr = 1'b0;
        m1_addr = 32'h2000_0004;
        m1_wdata = 32'hCAFE_F00D;
        m1_wstrb = 4'b0011;
        q1.push_back(rd_of(32'h2000_0004));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++; if (s_addr !== 32'd0 || s_wdata !== 32'd0 || s_wstrb !== 4'd0) begin errors++; $display("FAIL write_idle_bus: got %h/%h/%b expected zeros", s_addr, s_wdata, s_wstrb); end
            end
            if (grant === 2'b10) begin
                seen++;
                checks++; if (s_addr !== 32'h2000_0004) begin errors++; $display("FAIL write_s_addr: got %h expected 20000004", s_addr); end
                checks++; if (s_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL write_s_wdata: got %h expected cafef00d", s_wdata); end
                checks++; if (s_wstrb !== 4'b0011) begin errors++; $display("FAIL write_s_wstrb: got %b expected 0011", s_wstrb); end
                checks++; if (m0_ready !== 1'b0 || m0_rdata !== 32'd0) begin errors++; $display("FAIL write_m0_quiet: got ready=%b rdata=%h expected 0/0", m0_ready, m0_rdata); end
            end
            r1 = m1_ready;
            tick;
            if (r1) m1_valid = 1'b0;
        end
        checks++; if (seen != 3) begin errors++; $display("FAIL write_owned_cycles: got %0d expected 3", seen); end
        checks++; if (q1.size() != 0) begin errors++; $display("FAIL write_pending: got %0d expected 0", q1.size()); end
    endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
    task automatic test_timeout_race;
        logic r0;
        slv_lat = 7;
        m0_valid = 1'b1;
        m0_addr = 32'h300;
        q0.push_back(rd_of(32'h300));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (m0_ready !== (i == 8)) begin errors++; $display("FAIL race_m0_ready[%0d]: got %b expected %b", i, m0_ready, i == 8); end
            r0 = m0_ready;
            tick;
            if (r0) m0_valid = 1'b0;
        end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL race_timeout_err: got %b expected 0", timeout_err); end
    endtask

    task automatic test_timeout;
        logic r0;
        slv_mute = 1'b1;
        m0_valid = 1'b1;
        m0_addr = 32'h4000_9000;
        q0.push_back(ERR);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (m0_ready !== (i == 8)) begin errors++; $display("FAIL timeout_m0_ready[%0d]: got %b expected %b", i, m0_ready, i == 8); end
            checks++; if (s_valid !== (i >= 1 && i <= 7)) begin errors++; $display("FAIL timeout_s_valid[%0d]: got %b expected %b", i, s_valid, i >= 1 && i <= 7); end
            checks++; if (timeout_err !== (i >= 9)) begin errors++; $display("FAIL timeout_err[%0d]: got %b expected %b", i, timeout_err, i >= 9); end
            r0 = m0_ready;
            tick;
            if (r0) m0_valid = 1'b0;
        end
        slv_mute = 1'b0;
    endtask
`else
    task automatic test_timeout;
        bit hit = 1'b0;
        slv_mute = 1'b1;
        m0_valid = 1'b1;
        m0_addr = 32'h4000_9000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_ready) hit = 1'b1;
            tick;
        end
        checks++; if (hit) begin errors++; $display("FAIL timeout_none_ready: got ready expected none"); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_none_err: got %b expected 0", timeout_err); end
        m0_valid = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL abandon_hold: got %b expected 01", grant); end
        tick;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abandon_idle: got %b expected 00", grant); end
        tick;
        slv_mute = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        bit got = 1'b0;
        slv_mute = 1'b1;
        m1_valid = 1'b1;
        m1_addr = 32'h600;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = grant === 2'b10 && s_valid === 1'b1;
            if (!got) tick;
        end
        checks++; if (!got) begin errors++; $display("FAIL reset_mid_own1: got grant=%b expected 10 within 10 cycles", grant); end
        tick;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || s_valid !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_during: got grant=%b s_valid=%b m1_ready=%b expected 00/0/0", grant, s_valid, m1_ready); end
        tick;
        reset = 1'b0;
        m0_valid = 1'b1;
        m0_addr = 32'h700;
        @(negedge clk);
        checks++; if (grant !== 2'b00 || s_valid !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_after: got grant=%b s_valid=%b m1_ready=%b expected 00/0/0", grant, s_valid, m1_ready); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_mid_err: got %b expected 0", timeout_err); end
        tick;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL reset_mid_m0_first: got %b expected 01", grant); end
        tick;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        tick;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_mid_abandon: got %b expected 00", grant); end
        tick;
        slv_mute = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_write;
`ifdef MEM_ARBITER_TIMEOUT_EN
        test_timeout_race;
`endif
        test_timeout;
        test_reset_mid;
        checks++; if (q0.size() + q1.size() != 0) begin errors++; $display("FAIL final_pending: got %0d expected 0", q0.size() + q1.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
